// File: rtl/ex_stack_unit_pkg.sv
// Shared encodings and default widths for the J1-style execute-stage stack unit.
// Instruction classes and stack-delta codes are used by the unit, its LIFOs and benches.
package ex_stack_unit_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 13;

    typedef enum logic [3:0] {
        SEL_NOP  = 4'd0,
        SEL_LIT  = 4'd1,
        SEL_JMP  = 4'd2,
        SEL_CBR  = 4'd3,
        SEL_CALL = 4'd4,
        SEL_ALU  = 4'd5,
        SEL_LOAD = 4'd6
    } sel_e;

    typedef enum logic [1:0] {
        DELTA_NONE = 2'b00,
        DELTA_PUSH = 2'b01,
        DELTA_POP2 = 2'b10,
        DELTA_POP  = 2'b11
    } delta_e;

endpackage

// File: rtl/ex_stack_unit_if.sv
// ID/EX-to-execute bus of the stack unit; the master is the pipeline, the slave the unit.
// No handshake: one instruction is presented per cycle and always accepted on the next edge.
interface ex_stack_unit_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 13,
    parameter int DS_DEPTH   = 16,
    parameter int RS_DEPTH   = 16
);
    localparam int DSP_W = $clog2(DS_DEPTH);
    localparam int RSP_W = $clog2(RS_DEPTH);

    logic [3:0]            sel_i;
    logic [DATA_WIDTH-1:0] Immediate_i;
    logic [3:0]            stack_alu_i;
    logic                  return_alu_i;
    logic [ADDR_WIDTH-1:0] target_i;
    logic [ADDR_WIDTH-1:0] inst_addr_i;
    logic [DATA_WIDTH-1:0] T_m_i;
    logic [DATA_WIDTH-1:0] alu_t_i;
    logic [DATA_WIDTH-1:0] T_o;
    logic [DATA_WIDTH-1:0] N_o;
    logic [DATA_WIDTH-1:0] R_o;
    logic [DSP_W-1:0]      dsp_o;
    logic [RSP_W-1:0]      rsp_o;
    logic                  jump_flag_o;
    logic [ADDR_WIDTH-1:0] jump_addr_o;
    logic                  ds_err_o;
    logic                  rs_err_o;

    modport master (
        output sel_i, Immediate_i, stack_alu_i, return_alu_i, target_i,
               inst_addr_i, T_m_i, alu_t_i,
        input  T_o, N_o, R_o, dsp_o, rsp_o, jump_flag_o, jump_addr_o,
               ds_err_o, rs_err_o
    );

    modport slave (
        input  sel_i, Immediate_i, stack_alu_i, return_alu_i, target_i,
               inst_addr_i, T_m_i, alu_t_i,
        output T_o, N_o, R_o, dsp_o, rsp_o, jump_flag_o, jump_addr_o,
               ds_err_o, rs_err_o
    );
endinterface

// File: rtl/ex_stack_unit_lifo.sv
// Circular register-file stack: pointer addresses the top entry, push writes ptr+1.
// Sticky err flags a push from the last slot or a pop that crosses below slot 0.
module ex_lifo
    import ex_stack_unit_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int DEPTH    = 16,
    parameter bit HAS_POP2 = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [1:0]               delta,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         top,
    output logic [$clog2(DEPTH)-1:0] ptr,
    output logic                     err
);
    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    ptr_inc;
    logic [PW-1:0]    ptr_dec;
    logic [PW-1:0]    ptr_dec2;
    logic             do_push;
    logic             do_pop;
    logic             do_pop2;
    logic             over;
    logic             under;

    // Without pop-two support the 10 code is simply no operation.
    always_comb begin
        do_push  = (delta == DELTA_PUSH);
        do_pop   = (delta == DELTA_POP);
        do_pop2  = HAS_POP2 && (delta == DELTA_POP2);
        ptr_inc  = ptr + 1'b1;
        ptr_dec  = ptr - 1'b1;
        ptr_dec2 = ptr - PW'(2);
        over     = do_push && (ptr == PW'(DEPTH - 1));
        under    = (do_pop && (ptr == '0)) || (do_pop2 && (ptr < PW'(2)));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            err <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (over || under) begin
                err <= 1'b1;
            end
            if (do_push) begin
                ptr          <= ptr_inc;
                mem[ptr_inc] <= wdata;
            end else if (do_pop) begin
                ptr <= ptr_dec;
            end else if (do_pop2) begin
                ptr <= ptr_dec2;
            end
        end
    end

    assign top = mem[ptr];

endmodule

// File: rtl/ex_stack_unit.sv
// Execute-stage core of the J1-style stack CPU: T register, data/return stacks and
// control-transfer resolution. Jump outputs are combinational so ctrl flushes on the next edge.
module ex_stack_unit
    import ex_stack_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int DS_DEPTH   = 16,
    parameter int RS_DEPTH   = 16
) (
    input logic            clk,
    input logic            rst_n,
    ex_stack_unit_if.slave bus
);
    localparam int DSP_W = $clog2(DS_DEPTH);
    localparam int RSP_W = $clog2(RS_DEPTH);
    localparam int PAD   = DATA_WIDTH - ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] t_q;
    logic [DATA_WIDTH-1:0] t_next;
    logic [DATA_WIDTH-1:0] n_val;
    logic [DATA_WIDTH-1:0] r_val;
    logic [DATA_WIDTH-1:0] rs_wdata;
    logic [ADDR_WIDTH-1:0] ret_addr;
    logic [ADDR_WIDTH-1:0] jump_addr;
    logic [1:0]            ds_delta;
    logic [1:0]            rs_delta;
    logic [DSP_W-1:0]      dsp;
    logic [RSP_W-1:0]      rsp;
    logic                  ds_err;
    logic                  rs_err;
    logic                  jump_flag;

    // Class decode: each class picks its T source, its stack deltas and whether it jumps.
    always_comb begin
        ret_addr  = bus.inst_addr_i + 1'b1;
        t_next    = t_q;
        ds_delta  = DELTA_NONE;
        rs_delta  = DELTA_NONE;
        rs_wdata  = t_q;
        jump_flag = 1'b0;
        jump_addr = bus.target_i;
        case (bus.sel_i)
            SEL_LIT: begin
                ds_delta = DELTA_PUSH;
                t_next   = bus.Immediate_i;
            end
            SEL_JMP: begin
                jump_flag = 1'b1;
            end
            SEL_CBR: begin
                ds_delta  = DELTA_POP;
                t_next    = n_val;
                jump_flag = (t_q == '0);
            end
            SEL_CALL: begin
                rs_delta  = DELTA_PUSH;
                rs_wdata  = {{PAD{1'b0}}, ret_addr};
                jump_flag = 1'b1;
            end
            SEL_ALU: begin
                t_next   = bus.alu_t_i;
                ds_delta = bus.stack_alu_i[1:0];
                rs_delta = bus.stack_alu_i[3:2];
                if (bus.return_alu_i) begin
                    jump_flag = 1'b1;
                    jump_addr = r_val[ADDR_WIDTH-1:0];
                end
            end
            SEL_LOAD: begin
                t_next = bus.T_m_i;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q <= '0;
        end else begin
            t_q <= t_next;
        end
    end

    // The data stack always spills the old T; the return stack takes T or the return address.
    ex_lifo #(
        .WIDTH    (DATA_WIDTH),
        .DEPTH    (DS_DEPTH),
        .HAS_POP2 (1'b1)
    ) u_dstack (
        .clk   (clk),
        .rst_n (rst_n),
        .delta (ds_delta),
        .wdata (t_q),
        .top   (n_val),
        .ptr   (dsp),
        .err   (ds_err)
    );

    ex_lifo #(
        .WIDTH    (DATA_WIDTH),
        .DEPTH    (RS_DEPTH),
        .HAS_POP2 (1'b0)
    ) u_rstack (
        .clk   (clk),
        .rst_n (rst_n),
        .delta (rs_delta),
        .wdata (rs_wdata),
        .top   (r_val),
        .ptr   (rsp),
        .err   (rs_err)
    );

    assign bus.T_o         = t_q;
    assign bus.N_o         = n_val;
    assign bus.R_o         = r_val;
    assign bus.dsp_o       = dsp;
    assign bus.rsp_o       = rsp;
    assign bus.jump_flag_o = jump_flag;
    assign bus.jump_addr_o = jump_addr;
    assign bus.ds_err_o    = ds_err;
    assign bus.rs_err_o    = rs_err;

endmodule
